// File: rtl/softmax_group_ctrl_pkg.sv
// Shared types and constants for the softmax group sequencer.
// Legal group modes and the beats-per-group rule live here so FIFO, FSM and bench agree.
package softmax_ctrl_pkg;

   localparam int LAT_DEF  = 12;
   localparam int MODE_MIN = 3;
   localparam int MODE_MAX = 13;

   typedef enum logic {
      IDLE,
      STREAM
   } state_t;

   typedef struct packed {
      logic valid;
      logic first;
      logic last;
   } tag_t;

   function automatic logic [3:0] beats_of(input logic [3:0] mode);
      return mode - 4'd1;
   endfunction

endpackage

// File: rtl/softmax_group_ctrl_if.sv
// Command, beat, datapath and result handshake bundle for softmax_group_ctrl.
// The slave modport is the controller's view; master is the driving environment.
interface softmax_group_ctrl_if #(
   parameter int DW = 16
);
   logic                 i_cmd_valid;
   logic                 o_cmd_ready;
   logic [3:0]           i_cmd_mode;
   logic                 i_in_valid;
   logic                 o_in_ready;
   logic signed [DW-1:0] i_in_max;
   logic                 o_dp_en;
   logic                 o_dp_valid;
   logic signed [DW-1:0] o_dp_loc_max;
   logic [3:0]           o_dp_length_mode;
   logic                 o_dp_rst_loc;
   logic                 o_out_valid;
   logic                 i_out_ready;
   logic                 o_out_first;
   logic                 o_out_last;
   logic                 o_busy;
   logic                 o_err_cmd;

   modport slave (
      input  i_cmd_valid, i_cmd_mode, i_in_valid, i_in_max, i_out_ready,
      output o_cmd_ready, o_in_ready, o_dp_en, o_dp_valid, o_dp_loc_max,
             o_dp_length_mode, o_dp_rst_loc, o_out_valid, o_out_first,
             o_out_last, o_busy, o_err_cmd
   );

   modport master (
      output i_cmd_valid, i_cmd_mode, i_in_valid, i_in_max, i_out_ready,
      input  o_cmd_ready, o_in_ready, o_dp_en, o_dp_valid, o_dp_loc_max,
             o_dp_length_mode, o_dp_rst_loc, o_out_valid, o_out_first,
             o_out_last, o_busy, o_err_cmd
   );
endinterface

// File: rtl/softmax_group_ctrl_fifo.sv
// Small synchronous command FIFO with first-word fall-through read data,
// so the sequencer can load the next group mode in the same cycle it pops.
module ctrl_cmd_fifo #(
   parameter int W     = 4,
   parameter int DEPTH = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_push,
   input  logic [W-1:0] i_wdata,
   input  logic         i_pop,
   output logic [W-1:0] o_rdata,
   output logic         o_full,
   output logic         o_empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic [W-1:0] mem [DEPTH];

   assign o_empty = (wr_ptr == rd_ptr);
   assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign o_rdata = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (i_push && !o_full)  wr_ptr <= wr_ptr + PTR_ONE;
         if (i_pop  && !o_empty) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_push && !o_full) mem[wr_ptr[AW-1:0]] <= i_wdata;
   end

endmodule

// File: rtl/softmax_group_ctrl.sv
// Sequencer for the local-max accumulate / global-max forwarding datapath: feeds beats
// with group mode and local-reset timing, and carries aligned tags alongside the datapath.
module softmax_group_ctrl
   import softmax_ctrl_pkg::*;
#(
   parameter int LAT       = LAT_DEF,
   parameter int CMD_DEPTH = 4,
   parameter int DW        = 16
) (
   input logic                 i_clk,
   input logic                 i_rst,
   softmax_group_ctrl_if.slave bus
);
   localparam logic [3:0] MODE_LO = 4'(MODE_MIN);
   localparam logic [3:0] MODE_HI = 4'(MODE_MAX);

   logic       dp_en;
   state_t     state;
   logic [3:0] r_mode;
   logic [3:0] r_cnt;
   logic       err_q;

   logic       fifo_full;
   logic       fifo_empty;
   logic [3:0] fifo_rdata;
   logic       cmd_legal;
   logic       cmd_take;
   logic       fifo_push;
   logic       fifo_pop;
   logic       in_ready;
   logic       beat_acc;
   logic       last_beat;
   logic       tag_any;

   logic                 dp_vld_p0;
   logic                 dp_first_p0;
   logic                 dp_last_p0;
   logic signed [DW-1:0] dp_max_p0;
   logic [3:0]           dp_mode_p0;
   tag_t                 tag_p [LAT];

   // Only a downstream refusal of a presented result stalls the pipeline.
   assign dp_en     = ~(tag_p[LAT-1].valid & ~bus.i_out_ready);

   assign cmd_legal = (bus.i_cmd_mode >= MODE_LO) && (bus.i_cmd_mode <= MODE_HI);
   assign cmd_take  = bus.i_cmd_valid & ~fifo_full;
   assign fifo_push = cmd_take & cmd_legal;

   assign in_ready  = (state == STREAM) & dp_en;
   assign beat_acc  = bus.i_in_valid & in_ready;
   assign last_beat = (r_cnt == beats_of(r_mode) - 4'd1);
   assign fifo_pop  = dp_en & ~fifo_empty &
                      ((state == IDLE) | (beat_acc & last_beat));

   ctrl_cmd_fifo #(
      .W     (4),
      .DEPTH (CMD_DEPTH)
   ) u_cmd_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (fifo_push),
      .i_wdata (bus.i_cmd_mode),
      .i_pop   (fifo_pop),
      .o_rdata (fifo_rdata),
      .o_full  (fifo_full),
      .o_empty (fifo_empty)
   );

   // Illegal commands are consumed without stalling, so this flag ignores dp_en.
   always_ff @(posedge i_clk) begin
      if (i_rst) err_q <= 1'b0;
      else       err_q <= cmd_take & ~cmd_legal;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state  <= IDLE;
         r_cnt  <= 4'd0;
         r_mode <= 4'd0;
      end else if (dp_en) begin
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  r_mode <= fifo_rdata;
                  r_cnt  <= 4'd0;
                  state  <= STREAM;
               end
            end
            STREAM: begin
               if (beat_acc) begin
                  if (last_beat) begin
                     r_cnt <= 4'd0;
                     if (!fifo_empty) r_mode <= fifo_rdata;
                     else             state  <= IDLE;
                  end else begin
                     r_cnt <= r_cnt + 4'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Stage p0: datapath input register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         dp_vld_p0   <= 1'b0;
         dp_first_p0 <= 1'b0;
         dp_last_p0  <= 1'b0;
         dp_max_p0   <= '0;
         dp_mode_p0  <= 4'd0;
      end else if (dp_en) begin
         dp_vld_p0 <= beat_acc;
         if (beat_acc) begin
            dp_max_p0   <= bus.i_in_max;
            dp_mode_p0  <= r_mode;
            dp_first_p0 <= (r_cnt == 4'd0);
            dp_last_p0  <= last_beat;
         end
      end
   end

   // Tag stages: mirror the LAT enabled cycles of the datapath behind p0.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < LAT; i++) tag_p[i] <= '0;
      end else if (dp_en) begin
         tag_p[0] <= '{valid: dp_vld_p0,
                       first: dp_vld_p0 & dp_first_p0,
                       last:  dp_vld_p0 & dp_last_p0};
         for (int i = 1; i < LAT; i++) tag_p[i] <= tag_p[i-1];
      end
   end

   always_comb begin
      tag_any = 1'b0;
      for (int i = 0; i < LAT; i++) tag_any = tag_any | tag_p[i].valid;
   end

   assign bus.o_cmd_ready      = ~fifo_full;
   assign bus.o_in_ready       = in_ready;
   assign bus.o_dp_en          = dp_en;
   assign bus.o_dp_valid       = dp_vld_p0;
   assign bus.o_dp_loc_max     = dp_max_p0;
   assign bus.o_dp_length_mode = dp_mode_p0;
   assign bus.o_dp_rst_loc     = dp_vld_p0 & dp_last_p0;
   assign bus.o_out_valid      = tag_p[LAT-1].valid;
   assign bus.o_out_first      = tag_p[LAT-1].first;
   assign bus.o_out_last       = tag_p[LAT-1].last;
   assign bus.o_busy           = (state == STREAM) | tag_any | dp_vld_p0;
   assign bus.o_err_cmd        = err_q;

endmodule

// File: tb/tb_softmax_group_ctrl.sv
// Self-checking bench for softmax_group_ctrl: command table, scoreboarded beats,
// and hand-written sequences for latency, back-to-back groups, stall, FIFO full and reset.
module tb_softmax_group_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   softmax_group_ctrl_if #(.DW(16)) bus ();

   softmax_group_ctrl #(
      .LAT       (12),
      .CMD_DEPTH (4),
      .DW        (16)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
   endtask

   // ---------------- scoreboard model ----------------
   typedef struct packed {
      logic [15:0] d;
      logic [3:0]  m;
      logic        f;
      logic        l;
   } dpx_t;
   typedef struct packed {
      logic f;
      logic l;
   } ox_t;

   logic [3:0] mq[$];
   dpx_t       exp_dp[$];
   ox_t        exp_out[$];
   int         mcnt = 0;

   always @(negedge clk) begin
      if (rst) begin
         mq.delete();
         exp_dp.delete();
         exp_out.delete();
         mcnt = 0;
      end else begin
         if (bus.o_dp_valid && bus.o_dp_en) begin
            if (exp_dp.size() == 0) timeout_fail("dp_unexpected_beat");
            else begin
               dpx_t e;
               e = exp_dp.pop_front();
               chk("dp_loc_max", 32'(bus.o_dp_loc_max), 32'(e.d));
               chk("dp_length_mode", 32'(bus.o_dp_length_mode), 32'(e.m));
               chk("dp_rst_loc", 32'(bus.o_dp_rst_loc), 32'(e.l));
            end
         end
         if (bus.o_out_valid && bus.i_out_ready) begin
            if (exp_out.size() == 0) timeout_fail("out_unexpected_beat");
            else begin
               ox_t o;
               o = exp_out.pop_front();
               chk("out_first", 32'(bus.o_out_first), 32'(o.f));
               chk("out_last", 32'(bus.o_out_last), 32'(o.l));
            end
         end
         if (bus.i_cmd_valid && bus.o_cmd_ready &&
             bus.i_cmd_mode >= 4'd3 && bus.i_cmd_mode <= 4'd13)
            mq.push_back(bus.i_cmd_mode);
         if (bus.i_in_valid && bus.o_in_ready) begin
            if (mq.size() == 0) timeout_fail("beat_without_group");
            else begin
               logic [3:0] m;
               logic f, l;
               m = mq[0];
               f = (mcnt == 0);
               l = (mcnt == int'(m) - 2);
               exp_dp.push_back('{d: bus.i_in_max, m: m, f: f, l: l});
               exp_out.push_back('{f: f, l: l});
               if (l) begin
                  void'(mq.pop_front());
                  mcnt = 0;
               end else mcnt++;
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_neg_in_ready(input string name);
      int t = 0;
      @(negedge clk);
      while (!bus.o_in_ready && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (t >= 400) timeout_fail(name);
   endtask

   task automatic push_cmd(input logic [3:0] mode);
      int t = 0;
      bus.i_cmd_valid = 1'b1;
      bus.i_cmd_mode  = mode;
      @(negedge clk);
      while (!bus.o_cmd_ready && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (t >= 400) timeout_fail("cmd_ready_wait");
      step();
      bus.i_cmd_valid = 1'b0;
   endtask

   task automatic send_beat(input logic [15:0] d);
      bus.i_in_valid = 1'b1;
      bus.i_in_max   = d;
      wait_neg_in_ready("in_ready_wait");
      step();
      bus.i_in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      @(negedge clk);
      while (bus.o_busy && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (t >= 400) timeout_fail("idle_wait");
      step();
   endtask

   typedef struct {
      logic [3:0] mode;
      logic       exp_err;
      logic       exp_stream;
   } vec_t;

   vec_t vecs[8];

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish (t=%0t)", $time);
      $fatal(1, "global timeout");
   end

   initial begin
      logic        s_vld, s_rst, s_oval, s_of, s_ol;
      logic [15:0] s_max;
      logic [3:0]  s_mode;
      int          last_seen;

      vecs[0] = '{4'd2,  1'b1, 1'b0};
      vecs[1] = '{4'd3,  1'b0, 1'b1};
      vecs[2] = '{4'd14, 1'b1, 1'b0};
      vecs[3] = '{4'd13, 1'b0, 1'b1};
      vecs[4] = '{4'd0,  1'b1, 1'b0};
      vecs[5] = '{4'd15, 1'b1, 1'b0};
      vecs[6] = '{4'd7,  1'b0, 1'b1};
      vecs[7] = '{4'd1,  1'b1, 1'b0};

      bus.i_cmd_valid = 1'b0;
      bus.i_cmd_mode  = 4'd0;
      bus.i_in_valid  = 1'b0;
      bus.i_in_max    = 16'h0;
      bus.i_out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_cmd_ready", 32'(bus.o_cmd_ready), 32'd1);
      chk("rst_dp_en", 32'(bus.o_dp_en), 32'd1);
      chk("rst_in_ready", 32'(bus.o_in_ready), 32'd0);
      chk("rst_dp_valid", 32'(bus.o_dp_valid), 32'd0);
      chk("rst_dp_loc_max", 32'(bus.o_dp_loc_max), 32'd0);
      chk("rst_dp_mode", 32'(bus.o_dp_length_mode), 32'd0);
      chk("rst_dp_rst_loc", 32'(bus.o_dp_rst_loc), 32'd0);
      chk("rst_out_valid", 32'(bus.o_out_valid), 32'd0);
      chk("rst_out_first", 32'(bus.o_out_first), 32'd0);
      chk("rst_out_last", 32'(bus.o_out_last), 32'd0);
      chk("rst_busy", 32'(bus.o_busy), 32'd0);
      chk("rst_err_cmd", 32'(bus.o_err_cmd), 32'd0);
      step();

      // Test 1: single group, latency and local reset timing
      push_cmd(4'd3);
      bus.i_in_valid = 1'b1;
      bus.i_in_max   = 16'h0010;
      wait_neg_in_ready("t1_in_ready");
      step();
      bus.i_in_max = 16'h0020;
      @(negedge clk);
      chk("t1_in_ready_beat2", 32'(bus.o_in_ready), 32'd1);
      chk("t1_dp_valid_k1", 32'(bus.o_dp_valid), 32'd1);
      chk("t1_rst_loc_k1", 32'(bus.o_dp_rst_loc), 32'd0);
      step();
      bus.i_in_valid = 1'b0;
      for (int k = 2; k < 17; k++) begin
         @(negedge clk);
         chk($sformatf("t1_rst_loc_k%0d", k), 32'(bus.o_dp_rst_loc), 32'(k == 2));
         chk($sformatf("t1_out_valid_k%0d", k), 32'(bus.o_out_valid), 32'(k == 13 || k == 14));
         if (k == 13) begin
            chk("t1_first_k13", 32'(bus.o_out_first), 32'd1);
            chk("t1_last_k13", 32'(bus.o_out_last), 32'd0);
         end
         if (k == 14) begin
            chk("t1_first_k14", 32'(bus.o_out_first), 32'd0);
            chk("t1_last_k14", 32'(bus.o_out_last), 32'd1);
         end
         step();
      end
      wait_idle();

      // Command table: legal modes stream a full group, illegal ones pulse the error
      for (int v = 0; v < 8; v++) begin
         push_cmd(vecs[v].mode);
         @(negedge clk);
         chk($sformatf("tab%0d_err_pulse", v), 32'(bus.o_err_cmd), 32'(vecs[v].exp_err));
         step();
         @(negedge clk);
         chk($sformatf("tab%0d_err_clear", v), 32'(bus.o_err_cmd), 32'd0);
         chk($sformatf("tab%0d_stream", v), 32'(bus.o_in_ready), 32'(vecs[v].exp_stream));
         step();
         if (vecs[v].exp_stream)
            for (int b = 0; b < int'(vecs[v].mode) - 1; b++)
               send_beat(16'(16'h1000 + v * 16 + b));
         wait_idle();
      end

      // Test 2: back-to-back groups 3 then 4, no bubble
      push_cmd(4'd3);
      push_cmd(4'd4);
      bus.i_in_valid = 1'b1;
      bus.i_in_max   = 16'h0200;
      wait_neg_in_ready("t2_in_ready");
      for (int j = 0; j < 6; j++) begin
         if (j > 0) begin
            @(negedge clk);
            if (j < 5) chk($sformatf("t2_in_ready_b%0d", j + 1), 32'(bus.o_in_ready), 32'd1);
            chk($sformatf("t2_dp_valid_b%0d", j), 32'(bus.o_dp_valid), 32'd1);
            chk($sformatf("t2_mode_b%0d", j), 32'(bus.o_dp_length_mode),
                (j <= 2) ? 32'd3 : 32'd4);
            chk($sformatf("t2_rst_loc_b%0d", j), 32'(bus.o_dp_rst_loc),
                32'(j == 2 || j == 5));
         end
         step();
         if (j >= 4) bus.i_in_valid = 1'b0;
         else        bus.i_in_max = 16'(16'h0200 + j + 1);
      end
      wait_idle();

      // Test 3: backpressure for 5 cycles while results are valid and beats pending
      push_cmd(4'd13);
      push_cmd(4'd13);
      fork
         begin
            for (int i = 0; i < 24; i++) send_beat(16'(16'h0300 + i));
         end
         begin
            int t = 0;
            @(negedge clk);
            while (!bus.o_out_valid && t < 400) begin
               @(negedge clk);
               t++;
            end
            if (t >= 400) timeout_fail("t3_out_valid_wait");
            step();
            bus.i_out_ready = 1'b0;
            @(negedge clk);
            s_vld  = bus.o_dp_valid;
            s_max  = bus.o_dp_loc_max;
            s_mode = bus.o_dp_length_mode;
            s_rst  = bus.o_dp_rst_loc;
            s_oval = bus.o_out_valid;
            s_of   = bus.o_out_first;
            s_ol   = bus.o_out_last;
            for (int c = 0; c < 5; c++) begin
               if (c > 0) begin
                  @(negedge clk);
                  chk("t3_hold_dp_valid", 32'(bus.o_dp_valid), 32'(s_vld));
                  chk("t3_hold_dp_max", 32'(bus.o_dp_loc_max), 32'(s_max));
                  chk("t3_hold_dp_mode", 32'(bus.o_dp_length_mode), 32'(s_mode));
                  chk("t3_hold_rst_loc", 32'(bus.o_dp_rst_loc), 32'(s_rst));
                  chk("t3_hold_out_first", 32'(bus.o_out_first), 32'(s_of));
                  chk("t3_hold_out_last", 32'(bus.o_out_last), 32'(s_ol));
               end
               chk("t3_out_valid", 32'(bus.o_out_valid), 32'd1);
               chk("t3_dp_en", 32'(bus.o_dp_en), 32'd0);
               chk("t3_in_ready", 32'(bus.o_in_ready), 32'd0);
            end
            chk("t3_snapshot_valid", 32'(s_oval), 32'd1);
            step();
            bus.i_out_ready = 1'b1;
         end
      join
      wait_idle();

      // Test 4: illegal commands back to back
      bus.i_cmd_valid = 1'b1;
      bus.i_cmd_mode  = 4'd2;
      step();
      bus.i_cmd_mode  = 4'd14;
      @(negedge clk);
      chk("t4_err1", 32'(bus.o_err_cmd), 32'd1);
      step();
      bus.i_cmd_valid = 1'b0;
      @(negedge clk);
      chk("t4_err2", 32'(bus.o_err_cmd), 32'd1);
      step();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("t4_err_low", 32'(bus.o_err_cmd), 32'd0);
         chk("t4_in_ready_low", 32'(bus.o_in_ready), 32'd0);
         chk("t4_busy_low", 32'(bus.o_busy), 32'd0);
         step();
      end

      // Test 5: fill the command FIFO with no beats flowing
      for (int c = 0; c < 5; c++) begin
         bus.i_cmd_valid = 1'b1;
         bus.i_cmd_mode  = 4'd3;
         @(negedge clk);
         chk($sformatf("t5_cmd_ready_push%0d", c + 1), 32'(bus.o_cmd_ready), 32'd1);
         step();
      end
      bus.i_cmd_mode = 4'd5;
      @(negedge clk);
      chk("t5_cmd_ready_full", 32'(bus.o_cmd_ready), 32'd0);
      step();
      bus.i_cmd_valid = 1'b0;
      for (int b = 0; b < 10; b++) send_beat(16'(16'h0500 + b));
      wait_idle();
      chk("t5_groups_drained", 32'(mq.size()), 32'd0);

      // Test 6: reset during beat 3 of a mode-8 group
      push_cmd(4'd8);
      send_beat(16'h0601);
      send_beat(16'h0602);
      bus.i_in_valid = 1'b1;
      bus.i_in_max   = 16'h0603;
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.i_in_valid = 1'b0;
      @(negedge clk);
      chk("t6_dp_valid", 32'(bus.o_dp_valid), 32'd0);
      chk("t6_dp_loc_max", 32'(bus.o_dp_loc_max), 32'd0);
      chk("t6_dp_rst_loc", 32'(bus.o_dp_rst_loc), 32'd0);
      chk("t6_out_valid", 32'(bus.o_out_valid), 32'd0);
      chk("t6_busy", 32'(bus.o_busy), 32'd0);
      chk("t6_cmd_ready", 32'(bus.o_cmd_ready), 32'd1);
      chk("t6_in_ready", 32'(bus.o_in_ready), 32'd0);
      last_seen = 0;
      for (int c = 0; c < 30; c++) begin
         if (bus.o_out_last || bus.o_out_valid) last_seen++;
         @(negedge clk);
      end
      chk("t6_no_out_after_reset", 32'(last_seen), 32'd0);
      step();

      chk("end_exp_dp_empty", 32'(exp_dp.size()), 32'd0);
      chk("end_exp_out_empty", 32'(exp_out.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
